// File: rtl/score_keeper.sv
// score_keeper: match control downstream of ball_movement; keeps scores, runs serve pause and game over.
// Optional build macro SCORE_WIN_BY_TWO_EN: a win needs WIN_SCORE plus a two-point lead (or a saturated score).
module score_keeper #(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic               clk50M,
  input  logic               reset,
  input  logic               endofframe,
  input  logic [1:0]         missed,
  input  logic               start,
  output logic [SCORE_W-1:0] score_one,
  output logic [SCORE_W-1:0] score_two,
  output logic               ball_enable,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic               game_over,
  output logic [1:0]         winner
);
  // state | meaning
  // IDLE  | power-up, waiting for the first start press
  // SERVE | ball frozen and centred, pause counter runs down on frame ticks
  // PLAY  | ball moving, a miss at a frame tick scores a point
  // OVER  | winner decided, scores frozen until the next start press

  localparam int PAUSE_W = (PAUSE_FRAMES < 2) ? 1 : $clog2(PAUSE_FRAMES + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [PAUSE_W-1:0] PAUSE_LOAD = PAUSE_W'(PAUSE_FRAMES);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;
  state_t state, state_nxt;

  logic               eof_d1, eof_d2, start_d1, start_d2;
  logic               frame_tick, start_edge;
  logic [PAUSE_W-1:0] pause_cnt, pause_cnt_nxt;
  logic [SCORE_W-1:0] score_one_nxt, score_two_nxt, inc_one, inc_two;
  logic               ball_reset_nxt, serve_dir_nxt;
  logic [1:0]         winner_nxt;
  logic               one_wins, two_wins;

  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      eof_d1   <= 1'b0;
      eof_d2   <= 1'b0;
      start_d1 <= 1'b0;
      start_d2 <= 1'b0;
    end else begin
      eof_d1   <= endofframe;
      eof_d2   <= eof_d1;
      start_d1 <= start;
      start_d2 <= start_d1;
    end
  end

  assign frame_tick = eof_d1 & ~eof_d2;
  assign start_edge = start_d1 & ~start_d2;

  assign inc_one = (score_one == SCORE_MAX) ? score_one : score_one + SCORE_W'(1);
  assign inc_two = (score_two == SCORE_MAX) ? score_two : score_two + SCORE_W'(1);

`ifdef SCORE_WIN_BY_TWO_EN
  assign one_wins = (inc_one == SCORE_MAX) ||
                    ((inc_one >= WIN_VAL) &&
                     ({1'b0, inc_one} >= ({1'b0, score_two} + (SCORE_W+1)'(2))));
  assign two_wins = (inc_two == SCORE_MAX) ||
                    ((inc_two >= WIN_VAL) &&
                     ({1'b0, inc_two} >= ({1'b0, score_one} + (SCORE_W+1)'(2))));
`else
  assign one_wins = (inc_one == WIN_VAL);
  assign two_wins = (inc_two == WIN_VAL);
`endif

  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pause_cnt  <= '0;
      score_one  <= '0;
      score_two  <= '0;
      ball_reset <= 1'b0;
      serve_dir  <= 1'b0;
      winner     <= 2'b00;
    end else begin
      state      <= state_nxt;
      pause_cnt  <= pause_cnt_nxt;
      score_one  <= score_one_nxt;
      score_two  <= score_two_nxt;
      ball_reset <= ball_reset_nxt;
      serve_dir  <= serve_dir_nxt;
      winner     <= winner_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pause_cnt_nxt  = pause_cnt;
    score_one_nxt  = score_one;
    score_two_nxt  = score_two;
    serve_dir_nxt  = serve_dir;
    winner_nxt     = winner;
    ball_reset_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt      = SERVE;
          ball_reset_nxt = 1'b1;
          pause_cnt_nxt  = PAUSE_LOAD;
        end
      end
      SERVE: begin
        // A count of 0 or 1 means this tick is the last frame of the pause.
        if (frame_tick) begin
          if (pause_cnt <= PAUSE_W'(1)) begin
            pause_cnt_nxt = '0;
            state_nxt     = PLAY;
          end else begin
            pause_cnt_nxt = pause_cnt - PAUSE_W'(1);
          end
        end
      end
      PLAY: begin
        if (frame_tick && (missed != 2'b00)) begin
          state_nxt      = SERVE;
          ball_reset_nxt = 1'b1;
          pause_cnt_nxt  = PAUSE_LOAD;
          case (missed)
            2'b01: begin
              score_two_nxt = inc_two;
              serve_dir_nxt = 1'b0;
              if (two_wins) begin
                state_nxt      = OVER;
                winner_nxt     = 2'b10;
                ball_reset_nxt = 1'b0;
              end
            end
            2'b10: begin
              score_one_nxt = inc_one;
              serve_dir_nxt = 1'b1;
              if (one_wins) begin
                state_nxt      = OVER;
                winner_nxt     = 2'b01;
                ball_reset_nxt = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      OVER: begin
        if (start_edge) begin
          state_nxt      = SERVE;
          ball_reset_nxt = 1'b1;
          pause_cnt_nxt  = PAUSE_LOAD;
          score_one_nxt  = '0;
          score_two_nxt  = '0;
          winner_nxt     = 2'b00;
          serve_dir_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ball_enable = (state == PLAY);
  assign game_over   = (state == OVER);

endmodule
